// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller for the pipelined MIPS core.
// Holds the fetch PC, arbitrates branch/replay/jump/halt/stall sources with a
// fixed priority, and emits IF/ID and ID/EX squash pulses for the same edge.
//
// state   | meaning
// --------+-----------------------------------------------------------------
// BOOT    | post-reset settling; pc parked at RESET_PC, all requests ignored
// RUN     | normal fetch; one PC source accepted per cycle
// HALT    | fetch stopped at the held pc until resume
module pc_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_3000,
  parameter int unsigned BOOT_CYCLES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             br_taken_ex,
  input  logic [31:0]      br_target_ex,
  input  logic             jmp_id,
  input  logic [31:0]      jmp_target_id,
  input  logic             replay1,
  input  logic             replay2,
  input  logic             halt,
  input  logic             resume,
  output logic [31:0]      pc,
  output logic             fetch_valid,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             misalign_err,
  output logic [CNT_W-1:0] redirect_cnt
);

  localparam logic [1:0] ST_BOOT = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HALT = 2'd2;

  localparam logic [3:0] BOOT_LAST = 4'(BOOT_CYCLES - 1);

  logic [1:0]       r_state;
  logic [3:0]       r_boot_cnt;
  logic [31:0]      r_pc;
  logic             r_misalign;
  logic [CNT_W-1:0] r_redirect_cnt;

  logic             w_run;
  logic             w_take_br;
  logic             w_take_r2;
  logic             w_take_r1;
  logic             w_take_jmp;
  logic             w_take_halt;
  logic             w_take_stall;
  logic             w_redirect;
  logic [31:0]      w_target;
  logic             w_target_misaligned;
  logic [31:0]      w_pc_next;
  logic [1:0]       w_state_next;
  logic             w_boot_done;

  // Priority decode: each w_take_* is true only when every higher source is idle.
  always_comb begin
    w_run        = (r_state == ST_RUN);
    w_take_br    = w_run & br_taken_ex;
    w_take_r2    = w_run & ~br_taken_ex & replay2;
    w_take_r1    = w_run & ~br_taken_ex & ~replay2 & replay1;
    w_take_jmp   = w_run & ~br_taken_ex & ~replay2 & ~replay1 & jmp_id;
    w_take_halt  = w_run & ~br_taken_ex & ~replay2 & ~replay1 & ~jmp_id & halt;
    w_take_stall = w_run & ~br_taken_ex & ~replay2 & ~replay1 & ~jmp_id & ~halt & stall;
    w_redirect   = w_take_br | w_take_r2 | w_take_r1 | w_take_jmp;
  end

  // Redirect target selection; only branch and jump carry an external address.
  always_comb begin
    w_target            = w_take_br ? br_target_ex : jmp_target_id;
    w_target_misaligned = (w_take_br | w_take_jmp) & (w_target[1:0] != 2'b00);
  end

  // Next PC; all arithmetic wraps modulo 2^32 and loaded targets are word-aligned.
  always_comb begin
    w_pc_next = r_pc;
    if (w_take_br || w_take_jmp) begin
      w_pc_next = {w_target[31:2], 2'b00};
    end else if (w_take_r2) begin
      w_pc_next = r_pc - 32'd8;
    end else if (w_take_r1) begin
      w_pc_next = r_pc - 32'd4;
    end else if (w_run && !w_take_halt && !w_take_stall) begin
      w_pc_next = r_pc + 32'd4;
    end
  end

  // Next state; HALT listens to resume only, BOOT only to its own counter.
  always_comb begin
    w_boot_done  = (r_boot_cnt == BOOT_LAST);
    w_state_next = r_state;
    case (r_state)
      ST_BOOT: if (w_boot_done) w_state_next = ST_RUN;
      ST_RUN:  if (w_take_halt) w_state_next = ST_HALT;
      ST_HALT: if (resume)      w_state_next = ST_RUN;
      default: w_state_next = ST_BOOT;
    endcase
  end

  // State, PC and status registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state        <= ST_BOOT;
      r_boot_cnt     <= 4'd0;
      r_pc           <= RESET_PC;
      r_misalign     <= 1'b0;
      r_redirect_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      r_pc    <= w_pc_next;
      if (r_state == ST_BOOT && !w_boot_done) begin
        r_boot_cnt <= r_boot_cnt + 4'd1;
      end
      if (w_target_misaligned) begin
        r_misalign <= 1'b1;
      end
      if (w_redirect && (r_redirect_cnt != {CNT_W{1'b1}})) begin
        r_redirect_cnt <= r_redirect_cnt + 1'b1;
      end
    end
  end

  // Squash pulses act at the same edge that loads the new pc; silenced in reset.
  always_comb begin
    flush_ifid = rst_n & (w_redirect | w_take_halt);
    flush_idex = rst_n & (w_take_br | w_take_r2);
  end

  assign pc           = r_pc;
  assign fetch_valid  = (r_state == ST_RUN);
  assign misalign_err = r_misalign;
  assign redirect_cnt = r_redirect_cnt;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a reference model predicts each cycle,
// post-edge expectations go through a scoreboard queue.
module tb_pc_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam int          CNT_W    = 4;
  localparam int          CNT_MAX  = (1 << CNT_W) - 1;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             br_taken_ex;
  logic [31:0]      br_target_ex;
  logic             jmp_id;
  logic [31:0]      jmp_target_id;
  logic             replay1;
  logic             replay2;
  logic             halt;
  logic             resume;
  logic [31:0]      pc;
  logic             fetch_valid;
  logic             flush_ifid;
  logic             flush_idex;
  logic             misalign_err;
  logic [CNT_W-1:0] redirect_cnt;

  pc_sequencer #(
    .RESET_PC   (RESET_PC),
    .BOOT_CYCLES(2),
    .CNT_W      (CNT_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .stall        (stall),
    .br_taken_ex  (br_taken_ex),
    .br_target_ex (br_target_ex),
    .jmp_id       (jmp_id),
    .jmp_target_id(jmp_target_id),
    .replay1      (replay1),
    .replay2      (replay2),
    .halt         (halt),
    .resume       (resume),
    .pc           (pc),
    .fetch_valid  (fetch_valid),
    .flush_ifid   (flush_ifid),
    .flush_idex   (flush_idex),
    .misalign_err (misalign_err),
    .redirect_cnt (redirect_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic        fv;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t  sb_q[$];
  string tag_q[$];

  int checks = 0;
  int errors = 0;

  // reference model state: 0 boot, 1 run, 2 halt
  logic [31:0] m_pc;
  int          m_st = 0;
  int          m_boot = 0;
  logic        m_mis = 1'b0;
  int          m_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    stall = 0; br_taken_ex = 0; br_target_ex = 0; jmp_id = 0; jmp_target_id = 0;
    replay1 = 0; replay2 = 0; halt = 0; resume = 0;
  endtask

  task automatic model_redirect(input logic [31:0] tgt);
    m_pc = {tgt[31:2], 2'b00};
    if (tgt[1:0] != 2'b00) m_mis = 1'b1;
  endtask

  // One clock: predict, check the combinational flushes, then the registered state.
  task automatic tick(input string tag);
    logic e_fi, e_fe;
    exp_t e;
    exp_t got;
    string t;
    e_fi = 1'b0;
    e_fe = 1'b0;
    if (!rst_n) begin
      m_pc = RESET_PC; m_st = 0; m_boot = 0; m_mis = 1'b0; m_cnt = 0;
    end else if (m_st == 0) begin
      if (m_boot == 1) m_st = 1;
      else m_boot++;
    end else if (m_st == 2) begin
      if (resume) m_st = 1;
    end else begin
      if (br_taken_ex) begin
        model_redirect(br_target_ex); e_fi = 1; e_fe = 1;
      end else if (replay2) begin
        m_pc = m_pc - 32'd8; e_fi = 1; e_fe = 1;
      end else if (replay1) begin
        m_pc = m_pc - 32'd4; e_fi = 1;
      end else if (jmp_id) begin
        model_redirect(jmp_target_id); e_fi = 1;
      end else if (halt) begin
        m_st = 2; e_fi = 1;
      end else if (!stall) begin
        m_pc = m_pc + 32'd4;
      end
      if ((br_taken_ex || replay2 || replay1 || jmp_id) && m_cnt < CNT_MAX) m_cnt++;
    end
    e.pc = m_pc; e.fv = (m_st == 1); e.mis = m_mis; e.cnt = m_cnt;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    #1;
    chk({tag, ".flush_ifid"}, {31'd0, flush_ifid}, {31'd0, e_fi});
    chk({tag, ".flush_idex"}, {31'd0, flush_idex}, {31'd0, e_fe});
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, ".pc"}, pc, got.pc);
    chk({t, ".fetch_valid"}, {31'd0, fetch_valid}, {31'd0, got.fv});
    chk({t, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, got.mis});
    chk({t, ".redirect_cnt"}, {28'd0, redirect_cnt}, got.cnt);
    @(negedge clk);
  endtask

  initial begin
    clr();
    rst_n = 1'b0;
    m_pc = RESET_PC;
    @(negedge clk);

    br_taken_ex = 1; br_target_ex = 32'h8000;
    tick("reset");
    clr();
    chk("reset_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;

    br_taken_ex = 1; br_target_ex = 32'h8000; jmp_id = 1; jmp_target_id = 32'h9000; halt = 1;
    tick("boot0");
    clr();
    tick("boot1");
    chk("boot_done_pc", pc, 32'h0000_3000);
    tick("run_3004");
    tick("run_3008");
    tick("run_300c");
    tick("run_3010");

    br_taken_ex = 1; br_target_ex = 32'h4000; jmp_id = 1; jmp_target_id = 32'h5000;
    tick("br_over_jmp");
    clr();
    chk("tc_br_pc", pc, 32'h0000_4000);
    chk("tc_br_cnt", {28'd0, redirect_cnt}, 32'd1);

    jmp_id = 1; jmp_target_id = 32'h3010; tick("jmp_3010a"); clr();
    replay2 = 1; replay1 = 1; jmp_id = 1; jmp_target_id = 32'h7000;
    tick("replay2");
    clr();
    chk("tc_replay2_pc", pc, 32'h0000_3008);

    jmp_id = 1; jmp_target_id = 32'h3010; tick("jmp_3010b"); clr();
    replay1 = 1; stall = 1;
    tick("replay1");
    clr();
    chk("tc_replay1_pc", pc, 32'h0000_300C);

    jmp_id = 1; jmp_target_id = 32'h3020; tick("jmp_3020"); clr();
    stall = 1;
    for (int i = 0; i < 3; i++) tick("stall");
    chk("tc_stall_pc", pc, 32'h0000_3020);
    jmp_id = 1; jmp_target_id = 32'h3100;
    tick("stall_jmp");
    clr();
    halt = 1; replay1 = 1;
    tick("halt_replay1");
    clr();

    jmp_id = 1; jmp_target_id = 32'h3003;
    tick("jmp_misalign");
    clr();
    chk("tc_misalign_pc", pc, 32'h0000_3000);
    chk("tc_misalign_flag", {31'd0, misalign_err}, 32'd1);

    br_taken_ex = 1; br_target_ex = 32'hFFFF_FFFC;
    tick("br_top");
    clr();
    tick("wrap_up");
    chk("tc_wrap_pc", pc, 32'h0000_0000);
    tick("run_4");
    replay2 = 1;
    tick("wrap_down");
    clr();

    jmp_id = 1; jmp_target_id = 32'h3040;
    for (int i = 0; i < 6; i++) tick("jmp_sat");
    clr();
    chk("tc_cnt_sat", {28'd0, redirect_cnt}, CNT_MAX);

    halt = 1; stall = 1;
    tick("halt");
    clr();
    chk("tc_halt_pc", pc, 32'h0000_3040);
    br_taken_ex = 1; br_target_ex = 32'h6000; replay2 = 1; jmp_id = 1; jmp_target_id = 32'h6100;
    tick("halt_ignore");
    clr();
    resume = 1;
    tick("resume");
    clr();
    tick("after_resume");

    halt = 1; tick("halt2"); clr();
    rst_n = 1'b0;
    tick("reset_in_halt");
    chk("tc_rst_halt_pc", pc, 32'h0000_3000);
    rst_n = 1'b1;
    tick("reboot0");
    tick("reboot1");
    tick("rerun");

    chk("scoreboard_drained", sb_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
